seg_scan_driver: RTL and testbench

Downstream display stage for the clock: accepts the six active-low 7-segment codes (SS, MM, HH digit pairs) produced by the clock block and drives a multiplexed 6-digit common-anode display over one shared segment bus. Inputs are snapshotted once per frame so that a digit never changes mid-frame. A blanking gap between digits suppresses ghosting.

---
 rtl/seg_disp_pkg.sv | 30 +++
 rtl/seg_scan_if.sv | 31 +++
 rtl/seg_pwm.sv | 21 ++
 rtl/seg_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg_scan_driver.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_disp_pkg.sv
// Shared display definitions: digit count, segment widths, blank codes,
// segment bit positions and the scan FSM state type.
package seg_disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 7;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 6'h3F;

  // Segment bit positions on the active-low bus (a is the MSB).
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Active-low one-cold anode pattern selecting digit idx.
  function automatic logic [NUM_DIGITS-1:0] an_select(input logic [2:0] idx);
    an_select = ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Bundle between the clock block and the scan driver: six segment codes in,
// multiplexed display bus out. bright exists only with SEG_SCAN_PWM_EN.
interface seg_scan_if;
  import seg_disp_pkg::*;

  logic [SEG_W-1:0]      seg_in0;
  logic [SEG_W-1:0]      seg_in1;
  logic [SEG_W-1:0]      seg_in2;
  logic [SEG_W-1:0]      seg_in3;
  logic [SEG_W-1:0]      seg_in4;
  logic [SEG_W-1:0]      seg_in5;
`ifdef SEG_SCAN_PWM_EN
  logic [3:0]            bright;
`endif
  logic [SEG_W-1:0]      seg_out;
  logic [NUM_DIGITS-1:0] an_n;
  logic                  frame_pulse;

`ifdef SEG_SCAN_PWM_EN
  modport master (output seg_in0, seg_in1, seg_in2, seg_in3, seg_in4, seg_in5, bright,
                  input  seg_out, an_n, frame_pulse);
  modport slave  (input  seg_in0, seg_in1, seg_in2, seg_in3, seg_in4, seg_in5, bright,
                  output seg_out, an_n, frame_pulse);
`else
  modport master (output seg_in0, seg_in1, seg_in2, seg_in3, seg_in4, seg_in5,
                  input  seg_out, an_n, frame_pulse);
  modport slave  (input  seg_in0, seg_in1, seg_in2, seg_in3, seg_in4, seg_in5,
                  output seg_out, an_n, frame_pulse);
`endif

endinterface

// File: rtl/seg_pwm.sv
// Brightness PWM: free-running 4-bit counter, gate_on while counter <= bright.
// Only built with SEG_SCAN_PWM_EN.
`ifdef SEG_SCAN_PWM_EN
module seg_pwm (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bright,
  output logic       gate_on
);

  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (!reset) pwm_cnt <= 4'd0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign gate_on = (pwm_cnt <= bright);

endmodule
`endif

// File: rtl/seg_scan_driver.sv
// Multiplexed 6-digit common-anode scan driver with per-frame input snapshot
// and inter-digit blanking. Optional brightness PWM under SEG_SCAN_PWM_EN.
module seg_scan_driver
  import seg_disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 8333,
  parameter int BLANK_CYCLES = 64
) (
  input  logic     clk,
  input  logic     reset,
  seg_scan_if.slave bus
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);

  scan_state_t           state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [2:0]            idx, idx_nxt;
  logic                  load_shadow;
  logic [SEG_W-1:0]      shadow    [NUM_DIGITS];
  logic [SEG_W-1:0]      seg_in_arr[NUM_DIGITS];
  logic [SEG_W-1:0]      seg_q, seg_nxt;
  logic [NUM_DIGITS-1:0] an_q, an_nxt;
  logic                  pulse_q, pulse_nxt;
  logic                  gate_on;

  assign seg_in_arr[0] = bus.seg_in0;
  assign seg_in_arr[1] = bus.seg_in1;
  assign seg_in_arr[2] = bus.seg_in2;
  assign seg_in_arr[3] = bus.seg_in3;
  assign seg_in_arr[4] = bus.seg_in4;
  assign seg_in_arr[5] = bus.seg_in5;

`ifdef SEG_SCAN_PWM_EN
  seg_pwm u_pwm (
    .clk     (clk),
    .reset   (reset),
    .bright  (bus.bright),
    .gate_on (gate_on)
  );
`else
  assign gate_on = 1'b1;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    idx_nxt     = idx;
    load_shadow = 1'b0;
    unique case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt   = SHOW;
          cnt_nxt     = '0;
          load_shadow = (idx == 3'd0);
        end
      end
      SHOW: begin
        if (cnt == DWELL_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  // Display outputs follow the scan state one cycle later so all pins are registered.
  always_comb begin
    an_nxt    = AN_OFF;
    seg_nxt   = SEG_BLANK;
    pulse_nxt = 1'b0;
    if (state == SHOW) begin
      seg_nxt   = shadow[idx];
      pulse_nxt = (idx == 3'd0) && (cnt == '0);
      if (gate_on) an_nxt = an_select(idx);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= BLANK;
      cnt     <= '0;
      idx     <= 3'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      an_q    <= an_nxt;
      seg_q   <= seg_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  // NOTE: the shadow bank is reset explicitly so a blank code is defined before
  // the first snapshot; it is small enough to live in flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= SEG_BLANK;
    end else if (load_shadow) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= seg_in_arr[i];
    end
  end

  assign bus.an_n        = an_q;
  assign bus.seg_out     = seg_q;
  assign bus.frame_pulse = pulse_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver against a frame-arithmetic model.
module tb_seg_scan_driver;
  import seg_disp_pkg::*;

`ifdef SEG_SCAN_PWM_EN
  localparam int D = 32;
  localparam bit PWM_MODE = 1'b1;
`else
  localparam int D = 4;
  localparam bit PWM_MODE = 1'b0;
`endif
  localparam int B      = 2;
  localparam int SLOT   = B + D;
  localparam int PERIOD = 6 * SLOT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] tb_in [6];
  logic [6:0] in_prev [6];
  logic [6:0] in_now [6];
  logic [6:0] shadow_m [6];
  logic [5:0] an_e;
  logic [6:0] seg_e;
  logic       pulse_e;
  int e = -1;
  int off_e = 0;
  int lit_cnt = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_scan_if bus ();
  assign bus.seg_in0 = tb_in[0];
  assign bus.seg_in1 = tb_in[1];
  assign bus.seg_in2 = tb_in[2];
  assign bus.seg_in3 = tb_in[3];
  assign bus.seg_in4 = tb_in[4];
  assign bus.seg_in5 = tb_in[5];
`ifdef SEG_SCAN_PWM_EN
  logic [3:0] bright = 4'd15;
  assign bus.bright = bright;
`endif

  seg_scan_driver #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One clock edge with reset high, then compare outputs against the model.
  task automatic tick(input string tag);
    for (int i = 0; i < 6; i++) in_now[i] = tb_in[i];
    @(posedge clk);
    e++;
    if (e >= B && (e - B) % PERIOD == 0)
      for (int i = 0; i < 6; i++) shadow_m[i] = in_prev[i];
    for (int i = 0; i < 6; i++) in_prev[i] = in_now[i];
    an_e = 6'h3F; seg_e = 7'h7F; pulse_e = 1'b0; off_e = SLOT - 1;
    if (e >= B) begin
      int q = (e - B) % PERIOD;
      int d = q / SLOT;
      off_e   = q % SLOT;
      pulse_e = (q == 0);
      if (off_e < D) begin
        an_e  = ~(6'd1 << d);
        seg_e = shadow_m[d];
      end
    end
    @(negedge clk);
    checks++;
    if (bus.an_n !== an_e && !(PWM_MODE && an_e != 6'h3F && bus.an_n === 6'h3F)) begin
      errors++;
      $display("FAIL %s an_n e=%0d got %b exp %b", tag, e, bus.an_n, an_e);
    end
    if (an_e != 6'h3F && bus.an_n === an_e) lit_cnt++;
    checks++;
    if (bus.seg_out !== seg_e) begin
      errors++;
      $display("FAIL %s seg_out e=%0d got %b exp %b", tag, e, bus.seg_out, seg_e);
    end
    checks++;
    if (bus.frame_pulse !== pulse_e) begin
      errors++;
      $display("FAIL %s frame_pulse e=%0d got %b exp %b", tag, e, bus.frame_pulse, pulse_e);
    end
    checks++;
    if ($countones(~bus.an_n) > 1) begin
      errors++;
      $display("FAIL %s onehot e=%0d an_n got %b exp at most one low", tag, e, bus.an_n);
    end
    if (!PWM_MODE && bus.an_n === 6'h3F) begin
      checks++;
      if (bus.seg_out !== 7'h7F) begin
        errors++;
        $display("FAIL %s blank_seg e=%0d got %b exp 1111111", tag, e, bus.seg_out);
      end
    end
  endtask

  task automatic check_blank_in_reset(input string tag);
    checks++;
    if (bus.an_n !== 6'h3F || bus.seg_out !== 7'h7F || bus.frame_pulse !== 1'b0) begin
      errors++;
      $display("FAIL %s got an_n=%b seg=%b fp=%b exp 111111/1111111/0",
               tag, bus.an_n, bus.seg_out, bus.frame_pulse);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 6; i++) tb_in[i] = 7'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_blank_in_reset("reset");
    end
  endtask

  task automatic test_scan_order();
    tb_in[0] = 7'b0000001; tb_in[1] = 7'b1001111; tb_in[2] = 7'b0010010;
    tb_in[3] = 7'b0000110; tb_in[4] = 7'b1001100; tb_in[5] = 7'b0100100;
    for (int i = 0; i < 6; i++) shadow_m[i] = 7'h7F;
    reset = 1'b1;
    e = -1;
    for (int c = 0; c < 80; c++) begin
      tick("scan");
`ifndef SEG_SCAN_PWM_EN
      if (e == 2 || e == 5) begin
        checks++;
        if (bus.an_n !== 6'b111110 || bus.seg_out !== 7'b0000001) begin
          errors++;
          $display("FAIL scan_digit0 e=%0d got %b/%b exp 111110/0000001", e, bus.an_n, bus.seg_out);
        end
      end
      if (e == 6 || e == 7) begin
        checks++;
        if (bus.an_n !== 6'h3F || bus.seg_out !== 7'h7F) begin
          errors++;
          $display("FAIL scan_gap e=%0d got %b/%b exp 111111/1111111", e, bus.an_n, bus.seg_out);
        end
      end
      if (e == 8 || e == 11) begin
        checks++;
        if (bus.an_n !== 6'b111101 || bus.seg_out !== 7'b1001111) begin
          errors++;
          $display("FAIL scan_digit1 e=%0d got %b/%b exp 111101/1001111", e, bus.an_n, bus.seg_out);
        end
      end
      if (e == 2 || e == 38 || e == 74) begin
        checks++;
        if (bus.frame_pulse !== 1'b1) begin
          errors++;
          $display("FAIL scan_pulse e=%0d got %b exp 1", e, bus.frame_pulse);
        end
      end
`endif
    end
  endtask

  task automatic test_tear_free();
    int guard = 0;
    while (an_e != 6'b110111 && guard < PERIOD) begin tick("tear_wait"); guard++; end
    tb_in[0] = 7'b0100000;
    guard = 0;
    do begin tick("tear"); guard++; end while (!pulse_e && guard < 2 * PERIOD);
    checks++;
    if (bus.seg_out !== 7'b0100000 || guard >= 2 * PERIOD) begin
      errors++;
      $display("FAIL tear_new_frame got %b exp 0100000 (cycles %0d)", bus.seg_out, guard);
    end
    for (int c = 0; c < PERIOD; c++) tick("tear_after");
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (an_e != 6'b101111 && guard < PERIOD) begin tick("mid_wait"); guard++; end
    tick("mid_wait");
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_blank_in_reset("mid_reset");
    reset = 1'b1;
    e = -1;
    for (int i = 0; i < 6; i++) begin shadow_m[i] = 7'h7F; in_prev[i] = tb_in[i]; end
    for (int c = 0; c < 3; c++) tick("mid_resume");
    checks++;
    if (bus.frame_pulse !== 1'b1 || seg_e !== bus.seg_out || e != 2) begin
      errors++;
      $display("FAIL mid_resume_pulse got fp=%b seg=%b exp fp=1 seg=%b", bus.frame_pulse, bus.seg_out, seg_e);
    end
  endtask

  task automatic test_invariants();
    for (int c = 0; c < 20 * PERIOD; c++) begin
      if ($urandom_range(3) == 0) tb_in[$urandom_range(5)] = 7'($urandom);
      tick("random");
    end
  endtask

`ifdef SEG_SCAN_PWM_EN
  task automatic pwm_case(input logic [3:0] lvl, input int exp_lit);
    int guard = 0;
    bright = lvl;
    tick("pwm_settle");
    while (off_e != SLOT - 1 && guard < PERIOD) begin tick("pwm_wait"); guard++; end
    lit_cnt = 0;
    for (int c = 0; c < D; c++) tick("pwm");
    checks++;
    if (lit_cnt != exp_lit || guard >= PERIOD) begin
      errors++;
      $display("FAIL pwm bright=%0d lit got %0d exp %0d", lvl, lit_cnt, exp_lit);
    end
  endtask

  task automatic test_pwm();
    pwm_case(4'd3, 8);
    pwm_case(4'd15, 32);
    pwm_case(4'd0, 2);
    bright = 4'd15;
  endtask
`endif

  initial begin
    for (int i = 0; i < 6; i++) begin tb_in[i] = 7'h7F; in_prev[i] = 7'h7F; shadow_m[i] = 7'h7F; end
    @(negedge clk);
    test_reset();
    test_scan_order();
    test_tear_free();
    test_mid_reset();
    test_invariants();
`ifdef SEG_SCAN_PWM_EN
    test_pwm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
